// File: rtl/rv32_mem_stage.sv
// Memory-access pipeline stage: data bus handshake, load/store lane steering,
// branch resolution and the writeback register set.
module rv32_mem_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic        branch_predicted_taken_in,
  input  logic        alu_non_zero_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_fence_in,
  input  logic        mem_zero_extend_in,
  input  logic        rd_write_in,
  input  logic [1:0]  mem_width_in,
  input  logic [1:0]  branch_op_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] branch_pc_in,
  output logic [31:0] data_address_out,
  output logic        data_read_out,
  output logic        data_write_out,
  output logic [3:0]  data_write_mask_out,
  output logic [31:0] data_write_value_out,
  input  logic [31:0] data_read_value_in,
  input  logic        data_ready_in,
  output logic        busy_out,
  output logic        branch_mispredicted_out,
  output logic [31:0] branch_pc_out,
  output logic        valid_out,
  output logic        rd_write_out,
  output logic [4:0]  rd_out,
  output logic [31:0] rd_value_out
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [1:0] BrNever   = 2'd0;
  localparam logic [1:0] BrZero    = 2'd1;
  localparam logic [1:0] BrNonZero = 2'd2;
  localparam logic [1:0] BrAlways  = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] hold_q;
  logic        req;
  logic        capture;
  logic        taken;
  logic [1:0]  addr_lo;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  assign addr_lo = result_in[1:0];

  // Bus request; reset drops it at once, a fence never touches the bus.
  assign req = reset_n & valid_in & (mem_read_in | mem_write_in) & ~mem_fence_in &
               (state_q == StIdle);

  assign data_address_out = {result_in[31:2], 2'b00};
  assign data_read_out    = req & mem_read_in;
  assign data_write_out   = req & mem_write_in;
  assign busy_out         = req & ~data_ready_in;
  assign capture          = req & data_ready_in & stall_in;
  assign branch_pc_out    = branch_pc_in;

  // Store lane mask and replicated store data.
  always_comb begin
    data_write_mask_out  = 4'b1111;
    data_write_value_out = rs2_value_in;
    unique case (mem_width_in)
      2'd0: begin
        data_write_mask_out  = 4'b0001 << addr_lo;
        data_write_value_out = {4{rs2_value_in[7:0]}};
      end
      2'd1: begin
        data_write_mask_out  = addr_lo[1] ? 4'b1100 : 4'b0011;
        data_write_value_out = {2{rs2_value_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension; width 3 behaves as word.
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = addr_lo[1] ? data_read_value_in[31:16] : data_read_value_in[15:0];
    load_ext = data_read_value_in;
    unique case (addr_lo)
      2'd0: rd_byte = data_read_value_in[7:0];
      2'd1: rd_byte = data_read_value_in[15:8];
      2'd2: rd_byte = data_read_value_in[23:16];
      2'd3: rd_byte = data_read_value_in[31:24];
    endcase
    unique case (mem_width_in)
      2'd0: load_ext = mem_zero_extend_in ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'd1: load_ext = mem_zero_extend_in ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ;
    endcase
  end

  // Branch resolution against the fetch prediction.
  always_comb begin
    taken = 1'b0;
    unique case (branch_op_in)
      BrNever:   taken = 1'b0;
      BrZero:    taken = ~alu_non_zero_in;
      BrNonZero: taken = alu_non_zero_in;
      BrAlways:  taken = 1'b1;
    endcase
    branch_mispredicted_out = valid_in & (taken ^ branch_predicted_taken_in);
  end

  // Next state: park in HOLD when the bus finishes while the pipe is stalled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (capture) state_d = StHold;
      StHold: if (!stall_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and held load data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (capture) hold_q <= load_ext;
    end
  end

  // Writeback registers; flush kills the instruction but not the bus access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out    <= 1'b0;
      rd_write_out <= 1'b0;
      rd_out       <= 5'd0;
      rd_value_out <= 32'h0;
    end else if (!stall_in) begin
      valid_out    <= valid_in & ~flush_in;
      rd_write_out <= rd_write_in & ~flush_in;
      rd_out       <= rd_in;
      if (mem_read_in) rd_value_out <= (state_q == StHold) ? hold_q : load_ext;
      else             rd_value_out <= result_in;
    end
  end

endmodule
